// File: rtl/str_seq_pkg.sv
// Shared types and constants for the two-buffer string command sequencer.
// Holds the opcode and FSM state encodings, the default buffer size and the CMP result codes.
package str_seq_pkg;

    localparam int MAXLEN_DEF = 16;

    typedef enum logic [2:0] {
        OP_CLR    = 3'd0,
        OP_APPEND = 3'd1,
        OP_PUTC   = 3'd2,
        OP_GETC   = 3'd3,
        OP_LEN    = 3'd4,
        OP_UPPER  = 3'd5,
        OP_CMP    = 3'd6,
        OP_COPY   = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_UPPER = 3'd1,
        ST_CMP   = 3'd2,
        ST_COPY  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    localparam logic [7:0] CMP_LT = 8'hFF;
    localparam logic [7:0] CMP_EQ = 8'h00;
    localparam logic [7:0] CMP_GT = 8'h01;

    // ASCII lower-case letters map to upper case; every other byte passes through.
    function automatic logic [7:0] to_upper(input logic [7:0] c);
        if ((c >= 8'h61) && (c <= 8'h7A)) begin
            return c - 8'h20;
        end else begin
            return c;
        end
    endfunction

endpackage

// File: rtl/str_cmd_seq_buf.sv
// String buffer: byte array plus length register, one write port and two asynchronous read ports.
// Only the length is reset; bytes at or beyond the length are never observed.
module str_buf
    import str_seq_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEF,
    parameter int IW     = $clog2(MAXLEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [7:0]    wr_data,
    input  logic          len_we,
    input  logic [IW:0]   len_wdata,
    input  logic [IW-1:0] rd_idx_a,
    output logic [7:0]    rd_data_a,
    input  logic [IW-1:0] rd_idx_b,
    output logic [7:0]    rd_data_b,
    output logic [IW:0]   len
);

    logic [7:0]  mem_r [MAXLEN];
    logic [IW:0] len_r;

    // Byte storage write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    // Length register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_r <= '0;
        end else if (len_we) begin
            len_r <= len_wdata;
        end
    end

    assign rd_data_a = mem_r[rd_idx_a];
    assign rd_data_b = mem_r[rd_idx_b];
    assign len       = len_r;

endmodule

// File: rtl/str_cmd_seq.sv
// Command sequencer over two string buffers A and B: single-cycle edits and reads,
// plus byte-serial UPPER, CMP and COPY driven by a shared index counter.
module str_cmd_seq
    import str_seq_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEF,
    parameter int IW     = $clog2(MAXLEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic          cmd_sel,
    input  logic [IW-1:0] cmd_idx,
    input  logic [7:0]    cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [7:0]    rsp_data,
    output logic          rsp_err,
    output logic          busy
);

    localparam logic [IW:0] MAXLEN_C = (IW+1)'(MAXLEN);
    localparam logic [IW:0] ONE_C    = (IW+1)'(1);

    state_e        state_r, state_nx_s;
    logic [IW:0]   idx_r, idx_nx_s, step_s, min_len_s;
    logic          sel_r, sel_nx_s;
    logic [7:0]    rsp_data_r, rsp_data_nx_s;
    logic          rsp_err_r, rsp_err_nx_s;

    logic [1:0]          wr_en_s, len_we_s;
    logic [IW-1:0]       wr_idx_s;
    logic [7:0]          wr_data_s;
    logic [IW:0]         len_wdata_s;
    logic [1:0][IW:0]    len_s;
    logic [1:0][7:0]     rd_a_s, rd_b_s;

    str_buf #(.MAXLEN(MAXLEN), .IW(IW)) u_buf_a (
        .clk(clk), .rst(rst),
        .wr_en(wr_en_s[0]), .wr_idx(wr_idx_s), .wr_data(wr_data_s),
        .len_we(len_we_s[0]), .len_wdata(len_wdata_s),
        .rd_idx_a(cmd_idx), .rd_data_a(rd_a_s[0]),
        .rd_idx_b(idx_r[IW-1:0]), .rd_data_b(rd_b_s[0]),
        .len(len_s[0])
    );

    str_buf #(.MAXLEN(MAXLEN), .IW(IW)) u_buf_b (
        .clk(clk), .rst(rst),
        .wr_en(wr_en_s[1]), .wr_idx(wr_idx_s), .wr_data(wr_data_s),
        .len_we(len_we_s[1]), .len_wdata(len_wdata_s),
        .rd_idx_a(cmd_idx), .rd_data_a(rd_a_s[1]),
        .rd_idx_b(idx_r[IW-1:0]), .rd_data_b(rd_b_s[1]),
        .len(len_s[1])
    );

    assign step_s    = idx_r + ONE_C;
    assign min_len_s = (len_s[0] < len_s[1]) ? len_s[0] : len_s[1];

    // Next-state, buffer write controls and response capture.
    always_comb begin
        state_nx_s    = state_r;
        idx_nx_s      = idx_r;
        sel_nx_s      = sel_r;
        rsp_data_nx_s = rsp_data_r;
        rsp_err_nx_s  = rsp_err_r;
        wr_en_s       = 2'b00;
        len_we_s      = 2'b00;
        wr_idx_s      = '0;
        wr_data_s     = 8'h00;
        len_wdata_s   = '0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    sel_nx_s      = cmd_sel;
                    idx_nx_s      = '0;
                    rsp_data_nx_s = 8'h00;
                    rsp_err_nx_s  = 1'b0;
                    state_nx_s    = ST_RESP;
                    case (op_e'(cmd_op))
                        OP_CLR: begin
                            len_we_s[cmd_sel] = 1'b1;
                        end
                        OP_APPEND: begin
                            if (len_s[cmd_sel] < MAXLEN_C) begin
                                wr_en_s[cmd_sel]  = 1'b1;
                                wr_idx_s          = len_s[cmd_sel][IW-1:0];
                                wr_data_s         = cmd_data;
                                len_we_s[cmd_sel] = 1'b1;
                                len_wdata_s       = len_s[cmd_sel] + ONE_C;
                            end else begin
                                rsp_err_nx_s = 1'b1;
                            end
                        end
                        OP_PUTC: begin
                            if (({1'b0, cmd_idx} < len_s[cmd_sel]) && (cmd_data != 8'h00)) begin
                                wr_en_s[cmd_sel] = 1'b1;
                                wr_idx_s         = cmd_idx;
                                wr_data_s        = cmd_data;
                            end else begin
                                rsp_err_nx_s = 1'b1;
                            end
                        end
                        OP_GETC: begin
                            if ({1'b0, cmd_idx} < len_s[cmd_sel]) begin
                                rsp_data_nx_s = rd_a_s[cmd_sel];
                            end else begin
                                rsp_err_nx_s = 1'b1;
                            end
                        end
                        OP_LEN: begin
                            rsp_data_nx_s = 8'(len_s[cmd_sel]);
                        end
                        OP_UPPER: begin
                            if (len_s[cmd_sel] != '0) begin
                                state_nx_s = ST_UPPER;
                            end else begin
                                state_nx_s = ST_RESP;
                            end
                        end
                        OP_CMP: begin
                            state_nx_s = ST_CMP;
                        end
                        OP_COPY: begin
                            // An empty source finishes at once with an empty destination.
                            if (len_s[~cmd_sel] != '0) begin
                                state_nx_s = ST_COPY;
                            end else begin
                                len_we_s[cmd_sel] = 1'b1;
                            end
                        end
                        default: begin
                            rsp_err_nx_s = 1'b1;
                        end
                    endcase
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_UPPER: begin
                wr_en_s[sel_r] = 1'b1;
                wr_idx_s       = idx_r[IW-1:0];
                wr_data_s      = to_upper(rd_b_s[sel_r]);
                if (step_s == len_s[sel_r]) begin
                    state_nx_s = ST_RESP;
                end else begin
                    idx_nx_s = step_s;
                end
            end
            ST_CMP: begin
                if (idx_r == min_len_s) begin
                    if (len_s[0] < len_s[1]) begin
                        rsp_data_nx_s = CMP_LT;
                    end else if (len_s[0] > len_s[1]) begin
                        rsp_data_nx_s = CMP_GT;
                    end else begin
                        rsp_data_nx_s = CMP_EQ;
                    end
                    state_nx_s = ST_RESP;
                end else if (rd_b_s[0] != rd_b_s[1]) begin
                    rsp_data_nx_s = (rd_b_s[0] < rd_b_s[1]) ? CMP_LT : CMP_GT;
                    state_nx_s    = ST_RESP;
                end else begin
                    idx_nx_s = step_s;
                end
            end
            ST_COPY: begin
                wr_en_s[sel_r] = 1'b1;
                wr_idx_s       = idx_r[IW-1:0];
                wr_data_s      = rd_b_s[~sel_r];
                if (step_s == len_s[~sel_r]) begin
                    len_we_s[sel_r] = 1'b1;
                    len_wdata_s     = len_s[~sel_r];
                    state_nx_s      = ST_RESP;
                end else begin
                    idx_nx_s = step_s;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM, index counter and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= '0;
            sel_r      <= 1'b0;
            rsp_data_r <= 8'h00;
            rsp_err_r  <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            idx_r      <= idx_nx_s;
            sel_r      <= sel_nx_s;
            rsp_data_r <= rsp_data_nx_s;
            rsp_err_r  <= rsp_err_nx_s;
        end
    end

    assign cmd_ready = (state_r == ST_IDLE) && !rst;
    assign rsp_valid = (state_r == ST_RESP) && !rst;
    assign busy      = ((state_r == ST_UPPER) || (state_r == ST_CMP) || (state_r == ST_COPY)) && !rst;
    assign rsp_data  = rsp_data_r;
    assign rsp_err   = rsp_err_r;

endmodule
